mon_exp_win: RTL
================

# mon_exp_win

Parametrised successor to the bit-serial Montgomery exponentiation controller. It performs fixed-window (2^WIN-ary) left-to-right exponentiation and has synchronous reset, abort and a multiply counter. It sequences an external Montgomery multiplier over a small operand-slot memory, and never touches operand data itself: it only issues slot addresses and start pulses. It sits between the RSA top-level control and the Montgomery product unit.

## Interface
Clocking and reset (already decided): one clock; reset is synchronous and active-high.

Parameters:
- EBITS, 256, exponent width.
- LOG_EBITS, 8, width of e_idx; EBITS ≤ 2^LOG_EBITS.
- WIN, 2, window width in bits; legal 1..4.
- Derived localparams (not overridable):
  - SBITS = WIN+1, slot address width.
  - ACC = 2^WIN, accumulator slot.
  - ONE = 2^WIN+1, slot holding integer 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin exponentiation; sampled only in IDLE.
- abort  in  1  cancel current operation.
- e  in  EBITS  exponent; captured on accepted start.
- e_idx  in  LOG_EBITS  index of the highest bit to process; captured on start.
- mp_done  in  1  single-cycle pulse from the multiplier when a product is written.
- mp_start  out  1  single-cycle pulse that launches one product.
- mp_a_addr  out  SBITS  slot address of operand A.
- mp_b_addr  out  SBITS  slot address of operand B.
- mp_w_addr  out  SBITS  slot address of the product destination.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse; the result is in slot ACC.
- mul_count  out  16  products issued since the last accepted start; saturates at 0xFFFF.

## Operation
- The host preloads these slots before start:
  - slot 0 = R mod n (Montgomery one).
  - slot 1 = M·R mod n.
  - slot ONE = 1.
- Windows are aligned to bit 0.
  - Window count NW = e_idx/WIN + 1 (integer divide).
  - Window k covers bits [k·WIN+WIN-1 : k·WIN]. Bits above e_idx read as 0.
- States: IDLE, PRE, SCAN, COPY, SQR, MUL, FIN, WAIT, DONE. WAIT holds a return-state register.
- IDLE:
  - On start & !abort: capture e and e_idx, clear mul_count, set k = NW-1, set i = 2.
  - Go to PRE if WIN>1, else to SCAN.
- PRE: issue A=i-1, B=1, W=i (T[i] = T[i-1]·M). Increment i. When i reaches 2^WIN, the return state is SCAN.
- SCAN: tests one window per cycle.
  - Window k nonzero → COPY.
  - Window zero and k=0 → FIN, with the zero-exponent flag set.
  - Otherwise decrement k.
- COPY: issue A=0, B=v, W=ACC, where v is the window value. Then:
  - if k=0 → FIN;
  - else decrement k, set squaring counter s = WIN, go to SQR.
- SQR: issue A=ACC, B=ACC, W=ACC. Decrement s. When s reaches 0:
  - window k nonzero → MUL;
  - window k zero, k=0 → FIN;
  - window k zero, k>0 → decrement k, reload s, SQR.
- MUL: issue A=ACC, B=v, W=ACC. Then:
  - k=0 → FIN;
  - else decrement k, reload s, SQR.
- FIN: issue A=ACC (or A=0 if the zero-exponent flag is set), B=ONE, W=ACC. Return state is DONE.
- Every issue cycle asserts mp_start, increments mul_count, and enters WAIT.
- WAIT: the next state is the return state on mp_done. mp_done in any other state is ignored.
- DONE: pulse done for one cycle, then go to IDLE.
- abort in any non-IDLE state:
  - next state IDLE; no done pulse; mp_start is not asserted that cycle;
  - mul_count holds its value;
  - a late mp_done is ignored.
- start while busy is ignored.

## Timing
- Reset values of all outputs are 0. State after reset is IDLE.
- Reset mid-operation behaves exactly like abort and also clears mul_count.
- mp_start is high for exactly one cycle.
- mp_*_addr are valid in the mp_start cycle and held stable until the next issue.
- The next mp_start comes 1 cycle after mp_done is sampled. SCAN adds 1 cycle per window tested.
- Latency from start to done: 1 + Σ(multiplier latency + 1) + number of SCAN cycles + 1.
- Product count:
  - (2^WIN − 2) precompute products, plus WIN·(windows after the first nonzero window);
  - plus 1 per nonzero window (including COPY), plus 1 for FIN.
- If abort and mp_done arrive in the same cycle, abort wins.

## Test plan
- WIN=2, e=0b1011, e_idx=3. Required (A,B,W) sequence:
  - (1,1,2), (2,1,3), (0,2,4), (4,4,4), (4,4,4), (4,3,4), (4,5,4);
  - then done, with mul_count=7.
- WIN=2, e=0, e_idx=3: sequence (1,1,2), (2,1,3), (0,5,4); done, mul_count=3.
- WIN=1, e=1, e_idx=0: sequence (0,1,2), (2,3,2); done, mul_count=2. No PRE products.
- WIN=2, e=0b0100, e_idx=3 with 8-cycle multiplier latency: sequence (1,1,2), (2,1,3), (0,1,4), (4,4,4), (4,4,4), (4,5,4). The zero low window produces no MUL.
- abort pulsed during the third WAIT, with mp_done arriving 2 cycles later:
  - next cycle busy=0, no done, no further mp_start;
  - a new start then runs a correct full sequence.
- Spurious mp_done in IDLE, start while busy, and rst during SQR:
  - all ignored, or return to IDLE with all outputs 0 and mul_count=0.

Source files
------------

// File: rtl/mon_exp_win.sv
`default_nettype none
// ============================================================================
// Module      : mon_exp_win
// Description : Fixed-window (2^WIN-ary) left-to-right Montgomery
//               exponentiation controller. Sequences an external Montgomery
//               multiplier over a small operand-slot memory by issuing slot
//               addresses and start pulses; never touches operand data.
// Revision    : 1.0 - initial release
// ============================================================================
module mon_exp_win #(
    parameter int EBITS     = 256,
    parameter int LOG_EBITS = 8,
    parameter int WIN       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EBITS-1:0]     e,
    input  logic [LOG_EBITS-1:0] e_idx,
    input  logic                 mp_done,
    output logic                 mp_start,
    output logic [WIN:0]         mp_a_addr,
    output logic [WIN:0]         mp_b_addr,
    output logic [WIN:0]         mp_w_addr,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          mul_count
);

    localparam int SBITS = WIN + 1;
    localparam int SHW   = LOG_EBITS + 3;
    localparam logic [SBITS-1:0] ACC = SBITS'(1 << WIN);
    localparam logic [SBITS-1:0] ONE = SBITS'((1 << WIN) + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_PRE  = 4'd1,
        S_SCAN = 4'd2,
        S_COPY = 4'd3,
        S_SQR  = 4'd4,
        S_MUL  = 4'd5,
        S_FIN  = 4'd6,
        S_WAIT = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t               r_state, w_state_nxt;
    state_t               r_ret, w_ret_nxt;
    logic [EBITS-1:0]     r_e, w_e_nxt;
    logic [LOG_EBITS-1:0] r_k, w_k_nxt;
    logic [SBITS-1:0]     r_i, w_i_nxt;
    logic [2:0]           r_s, w_s_nxt;
    logic                 r_zero, w_zero_nxt;
    logic [SBITS-1:0]     r_a, r_b, r_w;
    logic [SBITS-1:0]     w_a, w_b, w_w;
    logic [15:0]          r_cnt, w_cnt_nxt;
    logic                 w_issue;

    logic [EBITS-1:0]     w_mask;
    logic [SHW-1:0]       w_shamt;
    logic [WIN-1:0]       w_v;
    logic [LOG_EBITS-1:0] w_k_start;

    // Exponent bits above e_idx are dropped at capture so they read as zero
    assign w_mask    = ~(({EBITS{1'b1}} << e_idx) << 1);
    assign w_k_start = LOG_EBITS'(int'(e_idx) / WIN);
    assign w_shamt   = SHW'(r_k) * SHW'(WIN);
    assign w_v       = WIN'(r_e >> w_shamt);

    // Next-state, slot addressing and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_e_nxt     = r_e;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_s_nxt     = r_s;
        w_zero_nxt  = r_zero;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        w_a         = r_a;
        w_b         = r_b;
        w_w         = r_w;

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_e_nxt     = e & w_mask;
                        w_k_nxt     = w_k_start;
                        w_i_nxt     = SBITS'(2);
                        w_zero_nxt  = 1'b0;
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = (WIN > 1) ? S_PRE : S_SCAN;
                    end
                end
                S_PRE: begin
                    w_issue   = 1'b1;
                    w_a       = r_i - SBITS'(1);
                    w_b       = SBITS'(1);
                    w_w       = r_i;
                    w_i_nxt   = r_i + SBITS'(1);
                    w_ret_nxt = ((r_i + SBITS'(1)) == ACC) ? S_SCAN : S_PRE;
                end
                S_SCAN: begin
                    if (w_v != '0) begin
                        w_state_nxt = S_COPY;
                    end else if (r_k == '0) begin
                        w_state_nxt = S_FIN;
                        w_zero_nxt  = 1'b1;
                    end else begin
                        w_k_nxt = r_k - LOG_EBITS'(1);
                    end
                end
                S_COPY: begin
                    w_issue = 1'b1;
                    w_a     = '0;
                    w_b     = SBITS'(w_v);
                    w_w     = ACC;
                    if (r_k == '0) begin
                        w_ret_nxt = S_FIN;
                    end else begin
                        w_k_nxt   = r_k - LOG_EBITS'(1);
                        w_s_nxt   = 3'(WIN);
                        w_ret_nxt = S_SQR;
                    end
                end
                S_SQR: begin
                    w_issue   = 1'b1;
                    w_a       = ACC;
                    w_b       = ACC;
                    w_w       = ACC;
                    w_s_nxt   = r_s - 3'd1;
                    w_ret_nxt = S_SQR;
                    if (r_s == 3'd1) begin
                        if (w_v != '0) begin
                            w_ret_nxt = S_MUL;
                        end else if (r_k == '0) begin
                            w_ret_nxt = S_FIN;
                        end else begin
                            w_k_nxt = r_k - LOG_EBITS'(1);
                            w_s_nxt = 3'(WIN);
                        end
                    end
                end
                S_MUL: begin
                    w_issue = 1'b1;
                    w_a     = ACC;
                    w_b     = SBITS'(w_v);
                    w_w     = ACC;
                    if (r_k == '0) begin
                        w_ret_nxt = S_FIN;
                    end else begin
                        w_k_nxt   = r_k - LOG_EBITS'(1);
                        w_s_nxt   = 3'(WIN);
                        w_ret_nxt = S_SQR;
                    end
                end
                S_FIN: begin
                    w_issue   = 1'b1;
                    w_a       = r_zero ? '0 : ACC;
                    w_b       = ONE;
                    w_w       = ACC;
                    w_ret_nxt = S_DONE;
                end
                S_WAIT: begin
                    if (mp_done) begin
                        w_state_nxt = r_ret;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            if (w_issue) begin
                w_state_nxt = S_WAIT;
                if (r_cnt != 16'hFFFF) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
        end
    end

    // State, operand-sequencing registers and held slot addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
            r_e     <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_s     <= '0;
            r_zero  <= 1'b0;
            r_cnt   <= 16'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_w     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_e     <= w_e_nxt;
            r_k     <= w_k_nxt;
            r_i     <= w_i_nxt;
            r_s     <= w_s_nxt;
            r_zero  <= w_zero_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_w     <= w_w;
        end
    end

    assign mp_start  = w_issue;
    assign mp_a_addr = w_a;
    assign mp_b_addr = w_b;
    assign mp_w_addr = w_w;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE) && !abort;
    assign mul_count = r_cnt;

endmodule
`default_nettype wire
